mdu_ctrl: RTL

- Multiply/divide unit controller for the E stage of the 5-stage pipeline.
- Accepts the decoded start, select and move-to controls, then latches the operands and computes the product or quotient/remainder.
- Holds busy for a fixed latency, then commits the result to the HI/LO registers.
- Serves mthi/mtlo writes and mfhi/mflo reads; the hazard unit stalls MDU instructions in D while (start | busy).

---
 rtl/mdu_ctrl_pkg.sv | 38 +++
 rtl/mdu_ctrl_if.sv | 28 ++
 rtl/mdu_ctrl_arith.sv | 72 +++++++
 rtl/mdu_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared constants, types and helpers for the multiply/divide unit.
//   MULDIV_* : operation/select codes from the decoder (MDUSel)
//   mdu_state_e : controller FSM states
//   mdu_res_t   : pending {hi,lo} result payload
package mdu_ctrl_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] MULDIV_DO_MUL     = 3'd0;
    localparam logic [SEL_W-1:0] MULDIV_DO_MULU    = 3'd1;
    localparam logic [SEL_W-1:0] MULDIV_DO_DIV     = 3'd2;
    localparam logic [SEL_W-1:0] MULDIV_DO_DIVU    = 3'd3;
    localparam logic [SEL_W-1:0] MULDIV_SELECT_HI  = 3'd4;
    localparam logic [SEL_W-1:0] MULDIV_SELECT_LO  = 3'd5;
    localparam logic [SEL_W-1:0] MULDIV_NONE       = 3'd7;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } mdu_res_t;

    // True for codes that launch a multi-cycle operation.
    function automatic logic is_mdu_op(input logic [SEL_W-1:0] s);
        return (s == MULDIV_DO_MUL) || (s == MULDIV_DO_MULU) ||
               (s == MULDIV_DO_DIV) || (s == MULDIV_DO_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [SEL_W-1:0] s);
        return (s == MULDIV_DO_MUL) || (s == MULDIV_DO_MULU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> MDU signal bundle.
//   master (pipeline): drives start, move_to, sel, flush, rs, rt
//   slave  (mdu_ctrl): drives busy, hi, lo, rd_data
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic              start;
    logic              move_to;
    logic [SEL_W-1:0]  sel;
    logic              flush;
    logic [XLEN-1:0]   rs;
    logic [XLEN-1:0]   rt;
    logic              busy;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   rd_data;

    modport master (
        output start, move_to, sel, flush, rs, rt,
        input  busy, hi, lo, rd_data
    );

    modport slave (
        input  start, move_to, sel, flush, rs, rt,
        output busy, hi, lo, rd_data
    );

endinterface

// File: rtl/mdu_ctrl_arith.sv
// mdu_arith: combinational multiply/divide datapath.
//   sel      : operation code (MUL/MULU/DIV/DIVU, others give zero)
//   a, b     : rs / rt operands
//   res_hi   : product[63:32] or remainder
//   res_lo   : product[31:0]  or quotient
//   div_zero : divide with b==0, result must not be committed
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  res_hi,
    output logic [XLEN-1:0]  res_lo,
    output logic             div_zero
);

    localparam int unsigned PW = 2 * XLEN;

    logic [PW-1:0]   prod_s;
    logic [PW-1:0]   prod_u;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] r_mag;
    logic [XLEN-1:0] q_u;
    logic [XLEN-1:0] r_u;
    logic            b_zero;

    // Low 64 bits of a 64x64 product of sign-extended operands equal the signed product.
    assign prod_s = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
    assign prod_u = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

    assign b_zero = (b == '0);

    // Signed divide on magnitudes; 0x80000000 magnitude stays representable unsigned.
    assign a_mag = a[XLEN-1] ? (~a + XLEN'(1)) : a;
    assign b_mag = b[XLEN-1] ? (~b + XLEN'(1)) : b;
    assign q_mag = b_zero ? '0 : (a_mag / b_mag);
    assign r_mag = b_zero ? '0 : (a_mag % b_mag);
    assign q_u   = b_zero ? '0 : (a / b);
    assign r_u   = b_zero ? '0 : (a % b);

    // Result select; quotient sign from operand signs, remainder sign from dividend.
    always_comb begin
        res_hi   = '0;
        res_lo   = '0;
        div_zero = 1'b0;
        case (sel)
            MULDIV_DO_MUL: begin
                res_hi = prod_s[PW-1:XLEN];
                res_lo = prod_s[XLEN-1:0];
            end
            MULDIV_DO_MULU: begin
                res_hi = prod_u[PW-1:XLEN];
                res_lo = prod_u[XLEN-1:0];
            end
            MULDIV_DO_DIV: begin
                div_zero = b_zero;
                res_lo   = (a[XLEN-1] ^ b[XLEN-1]) ? (~q_mag + XLEN'(1)) : q_mag;
                res_hi   = a[XLEN-1] ? (~r_mag + XLEN'(1)) : r_mag;
            end
            MULDIV_DO_DIVU: begin
                div_zero = b_zero;
                res_lo   = q_u;
                res_hi   = r_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide controller with HI/LO registers.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   mdu   : slave side of mdu_ctrl_if (start/move_to/sel/flush/rs/rt in,
//           busy/hi/lo registered out, rd_data combinational out)
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  mdu
);

    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    mdu_res_t         pend_q, pend_d;
    logic             dz_q, dz_d;

    logic [XLEN-1:0]  ar_hi;
    logic [XLEN-1:0]  ar_lo;
    logic             ar_dz;

    // Result is computed from the live operands and held until the busy period ends.
    mdu_arith u_arith (
        .sel      (mdu.sel),
        .a        (mdu.rs),
        .b        (mdu.rt),
        .res_hi   (ar_hi),
        .res_lo   (ar_lo),
        .div_zero (ar_dz)
    );

    // State, counter and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state: start wins over move_to; flush only gates new requests in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        dz_d    = dz_q;
        case (state_q)
            MDU_IDLE: begin
                if (!mdu.flush && mdu.start) begin
                    if (is_mdu_op(mdu.sel)) begin
                        state_d   = MDU_BUSY;
                        busy_d    = 1'b1;
                        cnt_d     = is_mul_op(mdu.sel) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                        pend_d.hi = ar_hi;
                        pend_d.lo = ar_lo;
                        dz_d      = ar_dz;
                    end
                end else if (!mdu.flush && mdu.move_to) begin
                    if (mdu.sel == MULDIV_SELECT_HI) begin
                        hi_d = mdu.rs;
                    end else if (mdu.sel == MULDIV_SELECT_LO) begin
                        lo_d = mdu.rs;
                    end
                end
            end
            MDU_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MDU_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    if (!dz_q) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = MDU_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign mdu.busy    = busy_q;
    assign mdu.hi      = hi_q;
    assign mdu.lo      = lo_q;
    assign mdu.rd_data = (mdu.sel == MULDIV_SELECT_HI) ? hi_q : lo_q;

endmodule
